// File: rtl/ebus_diag_master_if.sv
// EBUS diagnostic master bus bundle: front-end request/response handshake
// plus the EBUS diagnostic lines (ds, diagStrobe, data).
// Optional EBUS_DIAG_PARITY_CHK_EN adds ebus_parity_in / rsp_perr.
interface ebus_diag_master_if;
    // front-end request / response
    logic        req_valid;
    logic        req_ready;
    logic [0:6]  req_func;
    logic [0:35] req_data;
    logic        req_sweep;
    logic        rsp_valid;
    logic [0:35] rsp_data;
    logic [0:2]  rsp_sub;
    logic        done;
    // EBUS side
    logic [0:6]  ebus_ds;
    logic        ebus_diag_strobe;
    logic [0:35] ebus_data_out;
    logic        ebus_data_oe;
    logic [0:35] ebus_data_in;
`ifdef EBUS_DIAG_PARITY_CHK_EN
    logic        ebus_parity_in;
    logic        rsp_perr;

    modport master (
        input  req_valid, req_func, req_data, req_sweep, ebus_data_in, ebus_parity_in,
        output req_ready, rsp_valid, rsp_data, rsp_sub, done,
               ebus_ds, ebus_diag_strobe, ebus_data_out, ebus_data_oe, rsp_perr
    );
    modport slave (
        output req_valid, req_func, req_data, req_sweep, ebus_data_in, ebus_parity_in,
        input  req_ready, rsp_valid, rsp_data, rsp_sub, done,
               ebus_ds, ebus_diag_strobe, ebus_data_out, ebus_data_oe, rsp_perr
    );
`else
    modport master (
        input  req_valid, req_func, req_data, req_sweep, ebus_data_in,
        output req_ready, rsp_valid, rsp_data, rsp_sub, done,
               ebus_ds, ebus_diag_strobe, ebus_data_out, ebus_data_oe
    );
    modport slave (
        output req_valid, req_func, req_data, req_sweep, ebus_data_in,
        input  req_ready, rsp_valid, rsp_data, rsp_sub, done,
               ebus_ds, ebus_diag_strobe, ebus_data_out, ebus_data_oe
    );
`endif
endinterface

// File: rtl/ebus_diag_master.sv
// Console-side EBUS diagnostic initiator. Sequences one load or read
// function (or an 8-step read sweep over ds[4:6]) through
// SETUP -> STROBE -> HOLD, returning read data from the responders.
// Optional feature macro: EBUS_DIAG_PARITY_CHK_EN (odd-parity check on reads).
module ebus_diag_master #(
    parameter int SETUP_CYC  = 2,
    parameter int STROBE_CYC = 4,
    parameter int HOLD_CYC   = 2
) (
    input logic           clk,
    input logic           reset,
    ebus_diag_master_if.master bus
);
    localparam int MAX_AB = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
    localparam int MAXC   = (MAX_AB > HOLD_CYC) ? MAX_AB : HOLD_CYC;
    localparam int CW     = (MAXC > 1) ? $clog2(MAXC) : 1;

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, NEXT} state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt;
    logic [0:6]      ds_q;
    logic [0:35]     data_q;
    logic            sweep_q;
    logic            more;
    logic            sample;
    logic            rsp_valid_q, done_q;
    logic [0:35]     rsp_data_q;
    logic [0:2]      rsp_sub_q;

    // a sweep continues until sub-function 7 has been strobed
    assign more   = sweep_q && ds_q[0] && (ds_q[4:6] != 3'b111);
    // reads capture the bus on the final strobe cycle
    assign sample = (state == STROBE) && (cnt == '0) && ds_q[0];

    // next-state: each timed phase exits when its counter reaches zero
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (bus.req_valid) state_n = SETUP;
            SETUP:   if (cnt == '0) state_n = STROBE;
            STROBE:  if (cnt == '0) state_n = (HOLD_CYC > 0) ? HOLD : (more ? NEXT : IDLE);
            HOLD:    if (cnt == '0) state_n = more ? NEXT : IDLE;
            NEXT:    state_n = SETUP;
            default: state_n = IDLE;
        endcase
    end

    // state register and phase counter, reloaded on every state change
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            if (state_n != state) begin
                case (state_n)
                    SETUP:   cnt <= CW'(SETUP_CYC - 1);
                    STROBE:  cnt <= CW'(STROBE_CYC - 1);
                    HOLD:    cnt <= CW'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);
                    default: cnt <= '0;
                endcase
            end else if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    // request latch, sweep stepping, response capture and done pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            ds_q        <= '0;
            data_q      <= '0;
            sweep_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_sub_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            if (state == IDLE && bus.req_valid) begin
                // sweeps always start from sub-function 0
                ds_q    <= (bus.req_func[0] && bus.req_sweep) ? {bus.req_func[0:3], 3'b000}
                                                              : bus.req_func;
                data_q  <= bus.req_data;
                sweep_q <= bus.req_sweep && bus.req_func[0];
            end else if (state == NEXT) begin
                ds_q[4:6] <= ds_q[4:6] + 3'd1;
            end
            rsp_valid_q <= sample;
            if (sample) begin
                rsp_data_q <= bus.ebus_data_in;
                rsp_sub_q  <= ds_q[4:6];
            end
            done_q <= (state != IDLE) && (state_n == IDLE);
        end
    end

`ifdef EBUS_DIAG_PARITY_CHK_EN
    logic perr_q;
    // total parity over data+parity bit must be odd
    always_ff @(posedge clk) begin
        if (reset)       perr_q <= 1'b0;
        else if (sample) perr_q <= ~(^{bus.ebus_data_in, bus.ebus_parity_in});
        else             perr_q <= 1'b0;
    end
    assign bus.rsp_perr = perr_q;
`endif

    assign bus.req_ready        = (state == IDLE);
    assign bus.ebus_ds          = (state == IDLE) ? 7'd0 : ds_q;
    assign bus.ebus_diag_strobe = (state == STROBE);
    // never drive the data lines while a read function is selected
    assign bus.ebus_data_oe     = (state != IDLE) && !ds_q[0];
    assign bus.ebus_data_out    = bus.ebus_data_oe ? data_q : 36'd0;
    assign bus.rsp_valid        = rsp_valid_q;
    assign bus.rsp_data         = rsp_data_q;
    assign bus.rsp_sub          = rsp_sub_q;
    assign bus.done             = done_q;
endmodule
